// File: rtl/ahb_master_req_ctrl.sv
// ahb_master_req_ctrl
//   Master-side request and burst sequencer. Takes one command from a master
//   core, requests the bus, and once granted drives the address-phase
//   controls beat by beat. It drops the request after the last beat is
//   accepted. Only one transaction is ever in flight.
//
// Ports
//   hclk, hreset_n        clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (cmd_ready high only in IDLE)
//   cmd_addr/burst/len/size/write   command fields, captured on acceptance
//   hreq                  bus request to the arbiter
//   hgrant, hwait         grant (already masked by hwait) and slave stall
//   haddr/htrans/hburst/hsize/hwrite   registered address-phase controls
//   beat_done             combinational pulse per accepted beat
//   xfer_done             registered pulse in the cycle after the last beat
//   hprior                dynamic priority (only with AHB_MST_DYN_PRIOR_EN)
//
// Build option
//   AHB_MST_DYN_PRIOR_EN  adds the hprior output: it ages while waiting for
//                         a grant and clears on entry to the data transfer.
module ahb_master_req_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int PRIOR_BIT  = 2,
  parameter int AGE_CYCLES = 8
) (
  input  logic              hclk,
  input  logic              hreset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_burst,
  input  logic [3:0]        cmd_len,
  input  logic [2:0]        cmd_size,
  input  logic              cmd_write,
  output logic              hreq,
  input  logic              hgrant,
  input  logic              hwait,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic [2:0]        hburst,
  output logic [2:0]        hsize,
  output logic              hwrite,
  output logic              beat_done,
`ifdef AHB_MST_DYN_PRIOR_EN
  output logic [PRIOR_BIT-1:0] hprior,
`endif
  output logic              xfer_done
);

  // Wrap bounds reach 16 beats x 4 bytes, so the address must cover 64 bytes.
  if (ADDR_W < 6 || PRIOR_BIT < 1 || AGE_CYCLES < 1) begin : g_bad_cfg
    $error("ahb_master_req_ctrl: ADDR_W>=6, PRIOR_BIT>=1, AGE_CYCLES>=1 required");
  end

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_BUS, S_DONE} state_t;

  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic              hreq_reg, hreq_next;
  logic [ADDR_W-1:0] haddr_reg, haddr_next;
  logic [1:0]        htrans_reg, htrans_next;
  logic [2:0]        hburst_reg, hburst_next;
  logic [2:0]        hsize_reg, hsize_next;
  logic              hwrite_reg, hwrite_next;
  logic              xfer_done_reg, xfer_done_next;

  logic              accept;
  logic [2:0]        size_clamped;
  logic [ADDR_W-1:0] inc;
  logic [ADDR_W-1:0] wrap_mask;
  logic              is_wrap;
  logic [ADDR_W-1:0] addr_inc;
  logic [ADDR_W-1:0] addr_adv;

  // Beats minus one for a given burst type.
  function automatic logic [3:0] beats_m1(input logic [2:0] burst, input logic [3:0] len);
    case (burst)
      3'd0:       beats_m1 = 4'd0;
      3'd1:       beats_m1 = len;
      3'd2, 3'd3: beats_m1 = 4'd3;
      3'd4, 3'd5: beats_m1 = 4'd7;
      default:    beats_m1 = 4'd15;
    endcase
  endfunction

  assign accept       = (state_reg == S_BUS) && hgrant && !hwait;
  assign size_clamped = (cmd_size > 3'd2) ? 3'd2 : cmd_size;

  // Next-beat address. For wrapping bursts the low bits (inside the
  // beats*inc window) advance and wrap, the high bits are kept.
  always_comb begin
    inc       = ADDR_W'(1) << hsize_reg;
    is_wrap   = 1'b1;
    wrap_mask = '0;
    case (hburst_reg)
      3'd2:    wrap_mask = (inc << 2) - ADDR_W'(1);
      3'd4:    wrap_mask = (inc << 3) - ADDR_W'(1);
      3'd6:    wrap_mask = (inc << 4) - ADDR_W'(1);
      default: is_wrap   = 1'b0;
    endcase
    addr_inc = haddr_reg + inc;
    addr_adv = is_wrap ? ((haddr_reg & ~wrap_mask) | (addr_inc & wrap_mask)) : addr_inc;
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    hreq_next      = hreq_reg;
    haddr_next     = haddr_reg;
    htrans_next    = htrans_reg;
    hburst_next    = hburst_reg;
    hsize_next     = hsize_reg;
    hwrite_next    = hwrite_reg;
    xfer_done_next = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (cmd_valid) begin
          state_next  = S_REQ;
          hreq_next   = 1'b1;
          haddr_next  = cmd_addr;
          hburst_next = cmd_burst;
          hsize_next  = size_clamped;
          hwrite_next = cmd_write;
          cnt_next    = beats_m1(cmd_burst, cmd_len);
        end
      end
      S_REQ: begin
        if (hgrant) begin
          state_next  = S_BUS;
          htrans_next = TR_NONSEQ;
        end
      end
      S_BUS: begin
        // Without an accepted beat everything holds (stall or lost grant).
        if (accept) begin
          if (cnt_reg == 4'd0) begin
            state_next     = S_DONE;
            hreq_next      = 1'b0;
            htrans_next    = TR_IDLE;
            xfer_done_next = 1'b1;
          end else begin
            cnt_next    = cnt_reg - 4'd1;
            haddr_next  = addr_adv;
            htrans_next = TR_SEQ;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      hreq_reg      <= 1'b0;
      haddr_reg     <= '0;
      htrans_reg    <= TR_IDLE;
      hburst_reg    <= '0;
      hsize_reg     <= '0;
      hwrite_reg    <= 1'b0;
      xfer_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      hreq_reg      <= hreq_next;
      haddr_reg     <= haddr_next;
      htrans_reg    <= htrans_next;
      hburst_reg    <= hburst_next;
      hsize_reg     <= hsize_next;
      hwrite_reg    <= hwrite_next;
      xfer_done_reg <= xfer_done_next;
    end
  end

  assign cmd_ready = (state_reg == S_IDLE);
  assign beat_done = accept;
  assign hreq      = hreq_reg;
  assign haddr     = haddr_reg;
  assign htrans    = htrans_reg;
  assign hburst    = hburst_reg;
  assign hsize     = hsize_reg;
  assign hwrite    = hwrite_reg;
  assign xfer_done = xfer_done_reg;

`ifdef AHB_MST_DYN_PRIOR_EN
  localparam int AGE_W = (AGE_CYCLES > 1) ? $clog2(AGE_CYCLES) : 1;

  logic [AGE_W-1:0]     age_reg, age_next;
  logic [PRIOR_BIT-1:0] hprior_reg, hprior_next;

  // Priority ages only while requesting; the grant cycle clears it so the
  // first BUS cycle already shows 0.
  always_comb begin
    age_next    = age_reg;
    hprior_next = hprior_reg;
    if (state_reg == S_REQ) begin
      if (hgrant) begin
        age_next    = '0;
        hprior_next = '0;
      end else if (age_reg == AGE_W'(AGE_CYCLES - 1)) begin
        age_next = '0;
        if (hprior_reg != {PRIOR_BIT{1'b1}}) begin
          hprior_next = hprior_reg + PRIOR_BIT'(1);
        end
      end else begin
        age_next = age_reg + AGE_W'(1);
      end
    end
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      age_reg    <= '0;
      hprior_reg <= '0;
    end else begin
      age_reg    <= age_next;
      hprior_reg <= hprior_next;
    end
  end

  assign hprior = hprior_reg;
`endif

endmodule

// File: tb/tb_ahb_master_req_ctrl.sv
// tb_ahb_master_req_ctrl
//   Self-checking bench for ahb_master_req_ctrl. Each transaction is checked
//   cycle by cycle against a reference model that computes every beat address
//   in closed form (offset within the wrap window modulo the window size),
//   plus beat counts, release timing and stall accounting.
module tb_ahb_master_req_ctrl;
  localparam int AW = 32;

  logic          hclk = 1'b0;
  logic          hreset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [2:0]    cmd_burst = '0;
  logic [3:0]    cmd_len = '0;
  logic [2:0]    cmd_size = '0;
  logic          cmd_write = 1'b0;
  logic          hreq;
  logic          hgrant = 1'b0;
  logic          hwait = 1'b0;
  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic [2:0]    hburst;
  logic [2:0]    hsize;
  logic          hwrite;
  logic          beat_done;
  logic          xfer_done;
`ifdef AHB_MST_DYN_PRIOR_EN
  logic [1:0]    hprior;
`endif

  int checks = 0;
  int failures = 0;

  always #5 hclk = ~hclk;

  ahb_master_req_ctrl #(.ADDR_W(AW), .PRIOR_BIT(2), .AGE_CYCLES(4)) dut (
    .hclk(hclk), .hreset_n(hreset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_burst(cmd_burst), .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_write(cmd_write),
    .hreq(hreq), .hgrant(hgrant), .hwait(hwait),
    .haddr(haddr), .htrans(htrans), .hburst(hburst), .hsize(hsize), .hwrite(hwrite),
    .beat_done(beat_done),
`ifdef AHB_MST_DYN_PRIOR_EN
    .hprior(hprior),
`endif
    .xfer_done(xfer_done)
  );

  // ---------------- reference model ----------------
  function automatic int beats_of(input logic [2:0] b, input logic [3:0] len);
    case (b)
      3'd0:       return 1;
      3'd1:       return int'(len) + 1;
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      default:    return 16;
    endcase
  endfunction

  function automatic logic [2:0] eff_size(input logic [2:0] s);
    return (s > 3'd2) ? 3'd2 : s;
  endfunction

  // Address of beat i, computed directly from the start address.
  function automatic logic [31:0] model_addr(input logic [31:0] start, input logic [2:0] b,
                                             input logic [2:0] s, input int i);
    logic [31:0] inc, bound, base, off;
    inc = 32'd1 << eff_size(s);
    if (b == 3'd2 || b == 3'd4 || b == 3'd6) begin
      bound = 32'(beats_of(b, 4'd0)) * inc;
      base  = start - (start % bound);
      off   = (start - base + 32'(i) * inc) % bound;
      return base + off;
    end
    return start + 32'(i) * inc;
  endfunction

  // ---------------- transaction driver + checker ----------------
  task automatic run_xfer(input logic [2:0] b, input logic [3:0] len, input logic [31:0] addr,
                          input logic [2:0] s, input logic w, input int gdelay,
                          input int stall_beat, input int stall_len, input bit rnd,
                          output int bus_cycles);
    int beats, i, bus, stall_total, det_stalls, guard;
    bit stall;
    logic [31:0] ea;
    beats = beats_of(b, len);
    i = 0; bus = 0; stall_total = 0; det_stalls = 0; guard = 0;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++; $display("FAIL start_ready: cmd_ready=%b required 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_burst = b; cmd_len = len; cmd_addr = addr; cmd_size = s; cmd_write = w;
    hgrant = 1'b0; hwait = 1'b0;
    @(negedge hclk);
    cmd_valid = 1'b0;
    checks++;
    if ({hreq, htrans, cmd_ready, hburst, hsize, hwrite} !== {1'b1, 2'd0, 1'b0, b, eff_size(s), w}) begin
      failures++;
      $display("FAIL req_entry: hreq=%b htrans=%0d rdy=%b burst=%0d size=%0d wr=%b required 1 0 0 %0d %0d %b",
               hreq, htrans, cmd_ready, hburst, hsize, hwrite, b, eff_size(s), w);
    end
    for (int d = 0; d < gdelay; d++) begin
      hgrant = 1'b0;
      hwait = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      cmd_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge hclk);
      checks++;
      if ({hreq, htrans, cmd_ready} !== {1'b1, 2'd0, 1'b0}) begin
        failures++; $display("FAIL req_wait: hreq=%b htrans=%0d rdy=%b required 1 0 0", hreq, htrans, cmd_ready);
      end
    end
    hgrant = 1'b1; hwait = 1'b0; cmd_valid = 1'b0;
    #1;
    checks++;
    if (beat_done !== 1'b0) begin
      failures++; $display("FAIL req_no_beat: beat_done=%b required 0", beat_done);
    end
    @(negedge hclk);
    while (i < beats && guard < 200) begin
      ea = model_addr(addr, b, s, i);
      checks++;
      if ({hreq, htrans, haddr} !== {1'b1, (i == 0) ? 2'd2 : 2'd3, ea}) begin
        failures++;
        $display("FAIL beat%0d: hreq=%b htrans=%0d haddr=%h required 1 %0d %h",
                 i, hreq, htrans, haddr, (i == 0) ? 2 : 3, ea);
      end
      stall = 1'b0;
      if (i == stall_beat && det_stalls < stall_len) begin
        stall = 1'b1; det_stalls++;
      end else if (rnd && $urandom_range(0, 3) == 0) begin
        stall = 1'b1;
      end
      if (stall) begin
        hgrant = 1'b0; hwait = 1'($urandom_range(0, 1)); stall_total++;
      end else begin
        hgrant = 1'b1; hwait = 1'b0;
      end
      // Commands offered mid-transfer must be ignored.
      cmd_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      if (rnd) begin
        cmd_burst = 3'($urandom); cmd_addr = $urandom; cmd_size = 3'($urandom); cmd_write = ~w;
      end
      #1;
      checks++;
      if (beat_done !== !stall) begin
        failures++; $display("FAIL beat_done%0d: beat_done=%b required %b", i, beat_done, !stall);
      end
      if (!stall) i++;
      bus++; guard++;
      @(negedge hclk);
    end
    if (guard >= 200) begin
      failures++; $display("FAIL bus_timeout: beats seen %0d required %0d", i, beats);
    end
    hgrant = 1'b0; hwait = 1'b0; cmd_valid = 1'b0;
    checks++;
    if ({hreq, xfer_done, htrans, cmd_ready, hburst, hsize, hwrite} !==
        {1'b0, 1'b1, 2'd0, 1'b0, b, eff_size(s), w}) begin
      failures++;
      $display("FAIL release: hreq=%b xfer_done=%b htrans=%0d rdy=%b burst=%0d size=%0d wr=%b required 0 1 0 0 %0d %0d %b",
               hreq, xfer_done, htrans, cmd_ready, hburst, hsize, hwrite, b, eff_size(s), w);
    end
    @(negedge hclk);
    checks++;
    if ({cmd_ready, xfer_done, hreq} !== {1'b1, 1'b0, 1'b0}) begin
      failures++; $display("FAIL back_idle: rdy=%b xfer_done=%b hreq=%b required 1 0 0", cmd_ready, xfer_done, hreq);
    end
    checks++;
    if (bus != beats + stall_total) begin
      failures++; $display("FAIL bus_len: cycles=%0d required %0d", bus, beats + stall_total);
    end
    $display("xfer burst=%0d len=%0d addr=%h size=%0d wr=%b beats=%0d bus_cycles=%0d",
             b, len, addr, s, w, beats, bus);
    bus_cycles = bus;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    hreset_n = 1'b0;
    repeat (2) @(negedge hclk);
    checks++;
    if ({hreq, htrans, haddr, hburst, hsize, hwrite, beat_done, xfer_done, cmd_ready} !==
        {1'b0, 2'd0, 32'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_vals: hreq=%b htrans=%0d haddr=%h burst=%0d size=%0d wr=%b bd=%b xd=%b rdy=%b required all 0, rdy=1",
               hreq, htrans, haddr, hburst, hsize, hwrite, beat_done, xfer_done, cmd_ready);
    end
`ifdef AHB_MST_DYN_PRIOR_EN
    checks++;
    if (hprior !== 2'd0) begin
      failures++; $display("FAIL reset_prior: hprior=%0d required 0", hprior);
    end
`endif
    hreset_n = 1'b1;
    @(negedge hclk);
    checks++;
    if ({cmd_ready, hreq} !== {1'b1, 1'b0}) begin
      failures++; $display("FAIL post_reset: rdy=%b hreq=%b required 1 0", cmd_ready, hreq);
    end
  endtask

  task automatic test_single_write();
    int bc;
    run_xfer(3'd0, 4'd0, 32'h100, 3'd2, 1'b1, 3, -1, 0, 1'b0, bc);
    checks++;
    if (bc != 1) begin
      failures++; $display("FAIL single_len: bus cycles=%0d required 1", bc);
    end
  endtask

  task automatic test_incr4_stall();
    int bc;
    run_xfer(3'd3, 4'd0, 32'h10, 3'd2, 1'b0, 0, 1, 2, 1'b0, bc);
    checks++;
    if (bc != 6) begin
      failures++; $display("FAIL incr4_stall_len: bus cycles=%0d required 6", bc);
    end
  endtask

  task automatic test_wrap8_half();
    int bc;
    run_xfer(3'd4, 4'd0, 32'h2C, 3'd1, 1'b0, 1, -1, 0, 1'b0, bc);
  endtask

  task automatic test_incr_addr_wrap();
    int bc;
    run_xfer(3'd1, 4'd5, 32'hFFFF_FFFC, 3'd2, 1'b1, 0, -1, 0, 1'b0, bc);
  endtask

  task automatic test_reset_mid_burst();
    int bc;
    cmd_valid = 1'b1; cmd_burst = 3'd7; cmd_len = 4'd0; cmd_addr = 32'h400; cmd_size = 3'd2; cmd_write = 1'b1;
    @(negedge hclk);
    cmd_valid = 1'b0; hgrant = 1'b1; hwait = 1'b0;
    repeat (3) @(negedge hclk);
    checks++;
    if ({htrans, haddr} !== {2'd3, 32'h408}) begin
      failures++; $display("FAIL mid_beat3: htrans=%0d haddr=%h required 3 00000408", htrans, haddr);
    end
    #2 hreset_n = 1'b0;
    #1;
    checks++;
    if ({hreq, htrans, haddr, hburst, hsize, hwrite, beat_done, xfer_done, cmd_ready} !==
        {1'b0, 2'd0, 32'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL async_reset: hreq=%b htrans=%0d haddr=%h burst=%0d size=%0d wr=%b bd=%b xd=%b rdy=%b required all 0, rdy=1",
               hreq, htrans, haddr, hburst, hsize, hwrite, beat_done, xfer_done, cmd_ready);
    end
    hgrant = 1'b0;
    @(negedge hclk);
    hreset_n = 1'b1;
    @(negedge hclk);
    run_xfer(3'd0, 4'd0, 32'h44, 3'd0, 1'b0, 0, -1, 0, 1'b0, bc);
  endtask

  task automatic test_random();
    int bc, gd;
    logic [2:0] b, s;
    logic [3:0] len;
    logic [31:0] a;
    for (int n = 0; n < 30; n++) begin
      b = 3'($urandom); len = 4'($urandom); s = 3'($urandom);
      a = $urandom & ~((32'd1 << eff_size(s)) - 32'd1);
      gd = $urandom_range(0, 3);
      run_xfer(b, len, a, s, 1'($urandom), gd, -1, 0, 1'b1, bc);
    end
  endtask

`ifdef AHB_MST_DYN_PRIOR_EN
  task automatic test_aging();
    int e;
    cmd_valid = 1'b1; cmd_burst = 3'd0; cmd_addr = 32'h80; cmd_size = 3'd2; cmd_write = 1'b0;
    hgrant = 1'b0; hwait = 1'b0;
    @(negedge hclk);
    cmd_valid = 1'b0;
    for (int n = 0; n <= 20; n++) begin
      e = n / 4;
      if (e > 3) e = 3;
      checks++;
      if (hprior !== e[1:0]) begin
        failures++; $display("FAIL aging%0d: hprior=%0d required %0d", n, hprior, e);
      end
      if (n < 20) @(negedge hclk);
    end
    hgrant = 1'b1;
    @(negedge hclk);
    checks++;
    if ({hprior, htrans} !== {2'd0, 2'd2}) begin
      failures++; $display("FAIL aging_clear: hprior=%0d htrans=%0d required 0 2", hprior, htrans);
    end
    @(negedge hclk);
    hgrant = 1'b0;
    @(negedge hclk);
    $display("aging transaction complete");
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_incr4_stall();
    test_wrap8_half();
    test_incr_addr_wrap();
    test_reset_mid_burst();
    test_random();
`ifdef AHB_MST_DYN_PRIOR_EN
    test_aging();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
